icache_refill: RTL and testbench

Line-refill engine between the instruction cache and the 32-bit instruction memory bus. It accepts the cache's one-cycle miss request for a 16-byte line and fetches the line as four sequential word reads on a valid/ack bus. It assembles the words into a 128-bit block and returns it with a one-cycle ready pulse. It also handles redirect: the cache re-issuing a request mid-fill after a jump.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_refill.sv | 138 +++++++++++++
 tb/tb_icache_refill.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions.
// Holds the refill FSM state encoding, line geometry and the line-address
// alignment helper. The ICache uses the same offsets for its tag/index/offset split.
package icache_pkg;

    localparam int LINE_WORDS       = 4;
    localparam int LINE_OFFSET_BITS = 4;
    localparam int WORD_OFFSET_BITS = 2;

    // Clears the byte-in-line offset of a 32-bit byte address.
    localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } refill_state_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine.
// Takes a one-cycle miss request for a 16-byte line, fetches it as sequential
// word reads on a valid/ack bus, assembles the words in a private buffer and
// presents the finished line with a one-cycle ready pulse. A request arriving
// mid-fill (redirect) aborts the current line once its in-flight beat is acked.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   icache_addr_i       line address from the cache (low offset bits ignored)
//   icache_valid_req_i  one-cycle request pulse
//   mem_ready_o         one-cycle pulse, mem_data_o holds the completed line
//   mem_data_o          completed line, word i at [32i+31:32i]
//   bus_req_o           bus read request
//   bus_addr_o          word-aligned bus read address
//   bus_ack_i           bus read accepted, bus_rdata_i valid this cycle
//   bus_rdata_i         bus read data
//
// state | meaning
// IDLE  | waiting for a miss request
// FETCH | bus request active for word 'beat' of line 'base'
// DONE  | line complete, mem_ready_o high for this cycle only
module icache_refill #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            icache_addr_i,
    input  logic                             icache_valid_req_i,
    output logic                             mem_ready_o,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_data_o,
    output logic                             bus_req_o,
    output logic [ADDR_WIDTH-1:0]            bus_addr_o,
    input  logic                             bus_ack_i,
    input  logic [WORD_WIDTH-1:0]            bus_rdata_i
);
    import icache_pkg::*;

    localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LINE_WIDTH = LINE_WORDS * WORD_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

    refill_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] base;
    logic [BEAT_W-1:0]     beat;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [WORD_WIDTH-1:0] asm_buf [LINE_WORDS];
    logic [LINE_WIDTH-1:0] line_next;

    logic [ADDR_WIDTH-1:0] req_line;
    logic                  in_fetch;
    logic                  ack;
    logic                  redirect;
    logic                  last_beat;

    assign req_line  = icache_addr_i & ALIGN_MASK;
    assign in_fetch  = (state == FETCH);
    assign ack       = in_fetch && bus_ack_i;
    // A request coincident with an ack redirects that same beat.
    assign redirect  = pend_valid || icache_valid_req_i;
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

    assign bus_req_o   = in_fetch;
    assign bus_addr_o  = in_fetch ? (base + (ADDR_WIDTH'(beat) << WORD_OFFSET_BITS)) : '0;
    assign mem_ready_o = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (icache_valid_req_i) state_next = FETCH;
            end
            FETCH: begin
                if (ack && !redirect && last_beat) state_next = DONE;
            end
            DONE: begin
                state_next = icache_valid_req_i ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Completed line: buffered words plus the final word straight off the bus.
    always_comb begin
        line_next = '0;
        for (int i = 0; i < LINE_WORDS - 1; i++) begin
            line_next[i*WORD_WIDTH +: WORD_WIDTH] = asm_buf[i];
        end
        line_next[(LINE_WORDS-1)*WORD_WIDTH +: WORD_WIDTH] = bus_rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            beat       <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            mem_data_o <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                asm_buf[i] <= '0;
            end
        end else if (!in_fetch) begin
            if (icache_valid_req_i) begin
                base <= req_line;
                beat <= '0;
            end
        end else if (ack) begin
            if (redirect) begin
                // Aborted beat's data is dropped; restart on the newest address.
                base       <= icache_valid_req_i ? req_line : pend_addr;
                beat       <= '0;
                pend_valid <= 1'b0;
            end else begin
                asm_buf[beat] <= bus_rdata_i;
                beat          <= beat + BEAT_W'(1);
                if (last_beat) begin
                    mem_data_o <= line_next;
                end
            end
        end else if (icache_valid_req_i) begin
            pend_addr  <= req_line;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

    logic         clk;
    logic         rst_n;
    logic [31:0]  icache_addr_i;
    logic         icache_valid_req_i;
    logic         mem_ready_o;
    logic [127:0] mem_data_o;
    logic         bus_req_o;
    logic [31:0]  bus_addr_o;
    logic         bus_ack_i;
    logic [31:0]  bus_rdata_i;

    int total = 0;
    int bad   = 0;

    icache_refill #(
        .ADDR_WIDTH(32),
        .WORD_WIDTH(32),
        .LINE_WORDS(4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .icache_addr_i      (icache_addr_i),
        .icache_valid_req_i (icache_valid_req_i),
        .mem_ready_o        (mem_ready_o),
        .mem_data_o         (mem_data_o),
        .bus_req_o          (bus_req_o),
        .bus_addr_o         (bus_addr_o),
        .bus_ack_i          (bus_ack_i),
        .bus_rdata_i        (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LINE_W = 128'h000000D3_000000D2_000000D1_000000D0;
    localparam logic [127:0] LINE_B = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] LINE_C = 128'h00000043_00000042_00000041_00000040;
    localparam logic [127:0] LINE_D = 128'h00000063_00000062_00000061_00000060;
    localparam logic [127:0] LINE_E = 128'h00000073_00000072_00000071_00000070;
    localparam logic [127:0] LINE_F = 128'h000000F3_000000F2_000000F1_000000F0;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic test_reset();
        rst_n = 1'b0;
        icache_addr_i = '0;
        icache_valid_req_i = 1'b0;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0 || bus_addr_o !== 32'h0 || mem_data_o !== 128'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b rdy=%b addr=%h data=%h, required all zero",
                     bus_req_o, mem_ready_o, bus_addr_o, mem_data_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Ack without a request must be ignored.
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack_i = 1'b0;
        repeat (2) begin
            total++;
            if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_ack_ignored: req=%b rdy=%b, required 0 0", bus_req_o, mem_ready_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_1234;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h1230 + 32'(4*i)) || mem_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL basic_beat%0d: req=%b addr=%h rdy=%b, required 1 %h 0",
                         i, bus_req_o, bus_addr_o, mem_ready_o, 32'h1230 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_A || bus_req_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready: rdy=%b req=%b data=%h, required 1 0 %h", mem_ready_o, bus_req_o, mem_data_o, LINE_A);
        end
        @(negedge clk);
        total++;
        if (mem_ready_o !== 1'b0 || mem_data_o !== LINE_A) begin
            bad++;
            $display("FAIL basic_ready_one_cycle: rdy=%b data=%h, required 0 %h", mem_ready_o, mem_data_o, LINE_A);
        end
    endtask

    task automatic test_wait_states();
        int waits;
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_1234;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        waits = 0;
        // Cycles T+1..T+6: beat 1 is acked only on its third cycle.
        for (int c = 1; c <= 6; c++) begin
            logic [31:0] exp_addr;
            logic        give_ack;
            case (c)
                1: begin exp_addr = 32'h1230; give_ack = 1'b1; end
                2, 3: begin exp_addr = 32'h1234; give_ack = 1'b0; end
                4: begin exp_addr = 32'h1234; give_ack = 1'b1; end
                5: begin exp_addr = 32'h1238; give_ack = 1'b1; end
                default: begin exp_addr = 32'h123C; give_ack = 1'b1; end
            endcase
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== exp_addr || mem_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL wait_cycle%0d: req=%b addr=%h rdy=%b, required 1 %h 0",
                         c, bus_req_o, bus_addr_o, mem_ready_o, exp_addr);
            end
            bus_ack_i = give_ack;
            bus_rdata_i = give_ack ? (32'hD0 + 32'(waits)) : 32'hBAD0_0000;
            if (give_ack) waits++;
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_W) begin
            bad++;
            $display("FAIL wait_ready: rdy=%b data=%h, required 1 %h", mem_ready_o, mem_data_o, LINE_W);
        end
        @(negedge clk);
    endtask

    task automatic test_redirect();
        int rdy_cnt;
        rdy_cnt = 0;
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_1000;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            logic [31:0] exp_addr;
            exp_addr = (c == 1) ? 32'h1000 : (c == 2) ? 32'h1004 : 32'h1008;
            rdy_cnt += int'(mem_ready_o);
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== exp_addr) begin
                bad++;
                $display("FAIL redirect_old_cycle%0d: req=%b addr=%h, required 1 %h", c, bus_req_o, bus_addr_o, exp_addr);
            end
            icache_valid_req_i = (c == 3);
            icache_addr_i = (c == 3) ? 32'h0000_2040 : 32'h0;
            bus_ack_i = (c == 1 || c == 2 || c == 5);
            bus_rdata_i = (c == 5) ? 32'hDEAD_BEEF : 32'h11 + 32'(c);
            @(negedge clk);
        end
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy_cnt += int'(mem_ready_o);
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h2040 + 32'(4*i))) begin
                bad++;
                $display("FAIL redirect_new_beat%0d: req=%b addr=%h, required 1 %h",
                         i, bus_req_o, bus_addr_o, 32'h2040 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'hB0 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        rdy_cnt += int'(mem_ready_o);
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_B) begin
            bad++;
            $display("FAIL redirect_ready: rdy=%b data=%h, required 1 %h", mem_ready_o, mem_data_o, LINE_B);
        end
        @(negedge clk);
        rdy_cnt += int'(mem_ready_o);
        total++;
        if (rdy_cnt !== 1) begin
            bad++;
            $display("FAIL redirect_ready_count: saw %0d pulses, required 1", rdy_cnt);
        end
    endtask

    task automatic test_redirect_last_beat();
        int rdy_cnt;
        rdy_cnt = 0;
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_3000;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy_cnt += int'(mem_ready_o);
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h3000 + 32'(4*i))) begin
                bad++;
                $display("FAIL lastredir_old_beat%0d: req=%b addr=%h, required 1 %h",
                         i, bus_req_o, bus_addr_o, 32'h3000 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'h30 + 32'(i);
            icache_valid_req_i = (i == 3);
            icache_addr_i = (i == 3) ? 32'h0000_4008 : 32'h0;
            @(negedge clk);
        end
        icache_valid_req_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b0 || mem_data_o !== LINE_B) begin
            bad++;
            $display("FAIL lastredir_no_ready: rdy=%b data=%h, required 0 %h", mem_ready_o, mem_data_o, LINE_B);
        end
        for (int i = 0; i < 4; i++) begin
            rdy_cnt += int'(mem_ready_o);
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h4000 + 32'(4*i))) begin
                bad++;
                $display("FAIL lastredir_new_beat%0d: req=%b addr=%h, required 1 %h",
                         i, bus_req_o, bus_addr_o, 32'h4000 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'h40 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        rdy_cnt += int'(mem_ready_o);
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_C || rdy_cnt !== 1) begin
            bad++;
            $display("FAIL lastredir_ready: rdy=%b data=%h pulses=%0d, required 1 %h 1",
                     mem_ready_o, mem_data_o, rdy_cnt, LINE_C);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_0000;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== 32'(4*i)) begin
                bad++;
                $display("FAIL b2b_first_beat%0d: req=%b addr=%h, required 1 %h", i, bus_req_o, bus_addr_o, 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'h60 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b1 || bus_req_o !== 1'b0 || mem_data_o !== LINE_D) begin
            bad++;
            $display("FAIL b2b_first_ready: rdy=%b req=%b data=%h, required 1 0 %h", mem_ready_o, bus_req_o, mem_data_o, LINE_D);
        end
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_0010;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h10 + 32'(4*i)) || mem_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL b2b_second_beat%0d: req=%b addr=%h rdy=%b, required 1 %h 0",
                         i, bus_req_o, bus_addr_o, mem_ready_o, 32'h10 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'h70 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_E) begin
            bad++;
            $display("FAIL b2b_second_ready: rdy=%b data=%h, required 1 %h", mem_ready_o, mem_data_o, LINE_E);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_5000;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'h50 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h5008 || mem_data_o !== LINE_E) begin
            bad++;
            $display("FAIL rstmid_before: req=%b addr=%h data=%h, required 1 00005008 %h",
                     bus_req_o, bus_addr_o, mem_data_o, LINE_E);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0 || mem_data_o !== 128'h0 || bus_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async: req=%b rdy=%b addr=%h data=%h, required all zero",
                     bus_req_o, mem_ready_o, bus_addr_o, mem_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus_req_o !== 1'b0 || mem_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_no_spurious: req=%b rdy=%b, required 0 0", bus_req_o, mem_ready_o);
            end
        end
        icache_valid_req_i = 1'b1;
        icache_addr_i = 32'h0000_600C;
        @(negedge clk);
        icache_valid_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus_req_o !== 1'b1 || bus_addr_o !== (32'h6000 + 32'(4*i))) begin
                bad++;
                $display("FAIL rstmid_refill_beat%0d: req=%b addr=%h, required 1 %h",
                         i, bus_req_o, bus_addr_o, 32'h6000 + 32'(4*i));
            end
            bus_ack_i = 1'b1;
            bus_rdata_i = 32'hF0 + 32'(i);
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        total++;
        if (mem_ready_o !== 1'b1 || mem_data_o !== LINE_F) begin
            bad++;
            $display("FAIL rstmid_refill_ready: rdy=%b data=%h, required 1 %h", mem_ready_o, mem_data_o, LINE_F);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_redirect();
        test_redirect_last_beat();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
